// File: rtl/link_bist.sv
// Link self-test: a four-phase handshake pattern sender plus a receiver that checks
// the incoming words against its own copy of the pattern and reports pass/fail.
module link_bist #(
    parameter int DATA_W     = 32,
    parameter int SEND_COUNT = 100,
    parameter int PATTERN    = 0,
    parameter int TIMEOUT    = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic [DATA_W-1:0] do_tx,
    output logic              o_req_tx,
    output logic              o_sdone_tx,
    input  logic              i_ack_tx,
    input  logic              i_rdy_tx,
    input  logic [DATA_W-1:0] di_rx,
    input  logic              i_req_rx,
    input  logic              i_sdone_rx,
    output logic              o_ack_rx,
    output logic              o_rdy_rx,
    output logic              led,
    output logic              fail,
    output logic [15:0]       err_cnt,
    output logic [15:0]       rx_cnt
);

    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] WAIT_RDY = 3'd1;
    localparam logic [2:0] REQ      = 3'd2;
    localparam logic [2:0] REL      = 3'd3;
    localparam logic [2:0] DONE     = 3'd4;

    localparam logic [1:0] RIDLE = 2'd0;
    localparam logic [1:0] RACK  = 2'd1;
    localparam logic [1:0] REND  = 2'd2;

    function automatic logic [DATA_W-1:0] pat_seed();
        if (PATTERN == 0) return '1;
        else if (PATTERN == 1) return '0;
        else return DATA_W'(1);
    endfunction

    function automatic logic [DATA_W-1:0] pat_next(input logic [DATA_W-1:0] p);
        if (PATTERN == 0) return p - DATA_W'(1);
        else if (PATTERN == 1) return p + DATA_W'(1);
        else return {p[DATA_W-2:0], p[DATA_W-1]};
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [4:0]        sync_p0, sync_p1;
    logic              en_p2;
    logic              ack_s, rdy_s, req_s, sdone_s, en_s, en_rise;
    logic [2:0]        tx_state, tx_nxt;
    logic [DATA_W-1:0] tx_pat;
    logic [15:0]       tx_sent;
    logic [TW-1:0]     tx_wait;
    logic              tx_load, tx_adv, tx_to;
    logic [1:0]        rx_state, rx_nxt;
    logic [DATA_W-1:0] rx_pat;
    logic [TW-1:0]     rx_wait;
    logic              cap, rx_to, to_any, rend_entry;

    // Synchronizer stages for every handshake/control input
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            en_p2   <= 1'b0;
        end else begin
            sync_p0 <= {en, i_sdone_rx, i_req_rx, i_rdy_tx, i_ack_tx};
            sync_p1 <= sync_p0;
            en_p2   <= sync_p1[4];
        end
    end

    assign {en_s, sdone_s, req_s, rdy_s, ack_s} = sync_p1;
    assign en_rise = en_s & ~en_p2;

    assign tx_to = ((tx_state == WAIT_RDY) || (tx_state == REQ) || (tx_state == REL)) &&
                   (tx_wait == TW'(TIMEOUT - 1));
    assign rx_to  = (rx_state == RACK) && (rx_wait == TW'(TIMEOUT - 1));
    assign to_any = tx_to | rx_to;

    always_comb begin
        tx_nxt  = tx_state;
        tx_load = 1'b0;
        tx_adv  = 1'b0;
        case (tx_state)
            IDLE:     if (en_rise) tx_nxt = WAIT_RDY;
            WAIT_RDY: if (rdy_s) begin
                          tx_nxt  = REQ;
                          tx_load = 1'b1;
                      end
            REQ:      if (ack_s) tx_nxt = REL;
            REL:      if (!ack_s) begin
                          tx_adv = 1'b1;
                          tx_nxt = (tx_sent == 16'(SEND_COUNT - 1)) ? DONE : WAIT_RDY;
                      end
            DONE:     tx_nxt = DONE;
            default:  tx_nxt = IDLE;
        endcase
        // A low enable aborts the sender from any state
        if (!en_s || to_any) begin
            tx_nxt  = IDLE;
            tx_load = 1'b0;
            tx_adv  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_state <= IDLE;
            tx_wait  <= '0;
            tx_pat   <= pat_seed();
            tx_sent  <= '0;
            do_tx    <= '0;
        end else begin
            tx_state <= tx_nxt;
            tx_wait  <= (tx_nxt != tx_state) ? '0 : tx_wait + TW'(1);
            if (en_rise) begin
                tx_pat  <= pat_seed();
                tx_sent <= '0;
            end else if (tx_adv) begin
                tx_pat  <= pat_next(tx_pat);
                tx_sent <= tx_sent + 16'd1;
            end
            if (tx_load) do_tx <= tx_pat;
        end
    end

    always_comb begin
        rx_nxt = rx_state;
        cap    = 1'b0;
        case (rx_state)
            RIDLE:   if (req_s) begin
                         rx_nxt = RACK;
                         cap    = 1'b1;
                     end
            RACK:    if (!req_s) rx_nxt = RIDLE;
            REND:    if (en_rise) rx_nxt = RIDLE;
            default: rx_nxt = RIDLE;
        endcase
        // Send-done wins over everything; a timeout still lets a same-cycle capture count
        if (sdone_s) begin
            rx_nxt = REND;
            cap    = 1'b0;
        end else if (to_any) begin
            rx_nxt = RIDLE;
        end
    end

    assign rend_entry = (rx_nxt == REND) && (rx_state != REND);

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_state <= RIDLE;
            rx_wait  <= '0;
            rx_pat   <= pat_seed();
            err_cnt  <= '0;
            rx_cnt   <= '0;
            led      <= 1'b0;
            fail     <= 1'b0;
        end else begin
            rx_state <= rx_nxt;
            rx_wait  <= (rx_nxt != rx_state) ? '0 : rx_wait + TW'(1);
            if (en_rise) begin
                rx_pat  <= pat_seed();
                err_cnt <= '0;
                rx_cnt  <= '0;
                led     <= 1'b0;
                fail    <= 1'b0;
            end else begin
                if (cap) begin
                    rx_pat <= pat_next(rx_pat);
                    rx_cnt <= sat_inc(rx_cnt);
                    if (di_rx != rx_pat) err_cnt <= sat_inc(err_cnt);
                end
                if (to_any) begin
                    fail <= 1'b1;
                    led  <= 1'b0;
                end else if (rend_entry) begin
                    if (err_cnt == 16'd0 && rx_cnt == 16'(SEND_COUNT) && !fail) led <= 1'b1;
                    else begin
                        fail <= 1'b1;
                        led  <= 1'b0;
                    end
                end
            end
        end
    end

    assign o_req_tx   = (tx_state == REQ);
    assign o_sdone_tx = (tx_state == DONE);
    assign o_ack_rx   = (rx_state == RACK);
    assign o_rdy_rx   = (rx_state == RIDLE);

endmodule

// File: tb/tb_link_bist.sv
// Loopback bench for link_bist: three instances (decrement/32, increment/32, walking-one/8)
// checked against a pattern model with random ready stalls and bit-forcing faults.
module tb_link_bist;

    localparam int N   = 3;
    localparam int TMO = 16;
    localparam int DW_T  [N] = '{32, 32, 8};
    localparam int SC_T  [N] = '{4, 4, 9};
    localparam int PAT_T [N] = '{0, 1, 2};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst;
    logic [N-1:0]          en_k, ack_hold, fen;
    logic [N-1:0]          gate = '1;
    logic [N-1:0][5:0]     fbit;
    logic [N-1:0]          req_o, sdone_o, ack_o, rdy_o, led_o, fail_o;
    logic [N-1:0][31:0]    dtx_o;
    logic [N-1:0][15:0]    err_o, rxc_o;

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < N; g++) begin : inst
        localparam int DW = DW_T[g];
        logic [DW-1:0] do_tx, di_rx;
        logic          req, sdone, ack, rdy, led, fail;
        logic [15:0]   err_cnt, rx_cnt;

        assign di_rx = fen[g] ? (do_tx | (DW'(1) << fbit[g])) : do_tx;

        link_bist #(
            .DATA_W(DW), .SEND_COUNT(SC_T[g]), .PATTERN(PAT_T[g]), .TIMEOUT(TMO)
        ) dut (
            .clk(clk), .rst(rst), .en(en_k[g]),
            .do_tx(do_tx), .o_req_tx(req), .o_sdone_tx(sdone),
            .i_ack_tx(ack & ~ack_hold[g]), .i_rdy_tx(rdy & gate[g]),
            .di_rx(di_rx), .i_req_rx(req), .i_sdone_rx(sdone),
            .o_ack_rx(ack), .o_rdy_rx(rdy),
            .led(led), .fail(fail), .err_cnt(err_cnt), .rx_cnt(rx_cnt)
        );

        assign req_o[g]   = req;
        assign sdone_o[g] = sdone;
        assign ack_o[g]   = ack;
        assign rdy_o[g]   = rdy;
        assign led_o[g]   = led;
        assign fail_o[g]  = fail;
        assign dtx_o[g]   = 32'(do_tx);
        assign err_o[g]   = err_cnt;
        assign rxc_o[g]   = rx_cnt;
    end

    // Word monitor: record do_tx at every rising request
    logic [31:0]  words [N][256];
    int           nw [N] = '{0, 0, 0};
    logic [N-1:0] req_q = '0;
    always @(posedge clk) begin
        req_q <= req_o;
        for (int i = 0; i < N; i++)
            if (req_o[i] && !req_q[i] && nw[i] < 256) begin
                words[i][nw[i]] <= dtx_o[i];
                nw[i] <= nw[i] + 1;
            end
    end

    // Random far-end ready stalls
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) gate[i] = ($urandom_range(7) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    function automatic logic [31:0] model_word(input int i, input int k);
        logic [63:0] m;
        m = (64'd1 << DW_T[i]) - 64'd1;
        if (PAT_T[i] == 0) return 32'((m - 64'(k)) & m);
        else if (PAT_T[i] == 1) return 32'(64'(k) & m);
        else return 32'(64'd1 << (k % DW_T[i]));
    endfunction

    function automatic int model_err(input int i, input bit fe, input int fb);
        int n;
        logic [31:0] w;
        n = 0;
        if (fe)
            for (int k = 0; k < SC_T[i]; k++) begin
                w = model_word(i, k);
                if (w[fb] == 1'b0) n++;
            end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_reset(input int i, input string t);
        chk({t, "_req"},   64'(req_o[i]),   64'd0);
        chk({t, "_sdone"}, 64'(sdone_o[i]), 64'd0);
        chk({t, "_ack"},   64'(ack_o[i]),   64'd0);
        chk({t, "_rdy"},   64'(rdy_o[i]),   64'd1);
        chk({t, "_led"},   64'(led_o[i]),   64'd0);
        chk({t, "_fail"},  64'(fail_o[i]),  64'd0);
        chk({t, "_err"},   64'(err_o[i]),   64'd0);
        chk({t, "_rxcnt"}, 64'(rxc_o[i]),   64'd0);
        chk({t, "_dtx"},   64'(dtx_o[i]),   64'd0);
    endtask

    task automatic run_full(input int i, input bit fe, input int fb);
        int base, exp_err;
        bit done;
        fen[i]  = fe;
        fbit[i] = 6'(fb);
        base    = nw[i];
        en_k[i] = 1'b1;
        cyc(4);
        chk($sformatf("r%0d_clr_rxcnt", i), 64'(rxc_o[i]), 64'd0);
        chk($sformatf("r%0d_clr_err", i),   64'(err_o[i]), 64'd0);
        chk($sformatf("r%0d_clr_flags", i), 64'({led_o[i], fail_o[i]}), 64'd0);
        done = 1'b0;
        for (int k = 0; k < 800 && !done; k++) begin
            @(negedge clk);
            done = led_o[i] | fail_o[i];
        end
        chk($sformatf("r%0d_done", i), 64'(done), 64'd1);
        exp_err = model_err(i, fe, fb);
        chk($sformatf("r%0d_err_cnt", i), 64'(err_o[i]), 64'(exp_err));
        chk($sformatf("r%0d_rx_cnt", i),  64'(rxc_o[i]), 64'(SC_T[i]));
        chk($sformatf("r%0d_led", i),     64'(led_o[i]), 64'(exp_err == 0));
        chk($sformatf("r%0d_fail", i),    64'(fail_o[i]), 64'(exp_err != 0));
        chk($sformatf("r%0d_nwords", i),  64'(nw[i] - base), 64'(SC_T[i]));
        for (int k = 0; k < SC_T[i]; k++)
            chk($sformatf("r%0d_word%0d", i, k), 64'(words[i][base + k]), 64'(model_word(i, k)));
        en_k[i] = 1'b0;
        cyc(5);
        fen[i] = 1'b0;
    endtask

    initial begin
        int n, rises;
        bit got, prev;
        rst = 1'b0;
        en_k = '0;
        ack_hold = '0;
        fen = '0;
        fbit = '0;
        cyc(3);
        for (int i = 0; i < N; i++) chk_reset(i, $sformatf("por%0d", i));
        rst = 1'b1;
        cyc(3);

        run_full(0, 1'b0, 0);
        run_full(1, 1'b1, 0);
        run_full(1, 1'b1, int'($urandom_range(31)));
        run_full(2, 1'b0, 0);
        run_full(0, 1'b1, int'($urandom_range(31)));

        // Acknowledge stuck low: request must time out
        ack_hold[0] = 1'b1;
        en_k[0] = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            got = req_o[0];
        end
        chk("to_req_rise", 64'(got), 64'd1);
        n = 0;
        got = 1'b0;
        while (n < 25 && !got) begin
            @(negedge clk);
            n++;
            got = fail_o[0];
        end
        chk("to_window", 64'(n >= TMO && n <= TMO + 3), 64'd1);
        chk("to_led", 64'(led_o[0]), 64'd0);
        cyc(1);
        chk("to_req_low", 64'(req_o[0]), 64'd0);
        cyc(5);
        chk("to_req_stays_low", 64'(req_o[0]), 64'd0);
        en_k[0] = 1'b0;
        ack_hold[0] = 1'b0;
        cyc(10);

        // Abort after two transfers, then restart from the seed
        en_k[2] = 1'b1;
        rises = 0;
        prev = 1'b0;
        for (int k = 0; k < 300 && rises < 3; k++) begin
            @(negedge clk);
            if (req_o[2] && !prev) rises++;
            prev = req_o[2];
        end
        chk("ab_third_req", 64'(rises), 64'd3);
        en_k[2] = 1'b0;
        n = 0;
        while (n < 6 && req_o[2]) begin
            @(negedge clk);
            n++;
        end
        chk("ab_req_drop", 64'(n <= 3 && !req_o[2]), 64'd1);
        cyc(6);
        chk("ab_idle", 64'({req_o[2], sdone_o[2]}), 64'd0);
        chk("ab_partial_rx", 64'(rxc_o[2] >= 16'd2), 64'd1);
        cyc(6);
        run_full(2, 1'b0, 0);

        // Reset asserted while a request is outstanding
        en_k[0] = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            got = req_o[0];
        end
        chk("rs_req_high", 64'(got), 64'd1);
        rst = 1'b0;
        cyc(1);
        chk_reset(0, "rs");
        en_k[0] = 1'b0;
        rst = 1'b1;
        cyc(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/link_bist.md
LINK_BIST -- requirements
Module: link_bist

Interface
REQ-001 Parameter DATA_W, default 32, data bus width in bits (8..64).
REQ-002 Parameter SEND_COUNT, default 100, number of words per run (1..65535).
REQ-003 Parameter PATTERN, default 0, selects the pattern: 0 = decrement from all-ones, 1 = increment from 0, 2 = walking-one rotate-left starting at 1.
REQ-004 Parameter TIMEOUT, default 1024, maximum cycles spent waiting in any handshake state.
REQ-005 clk  in  1  single clock for the sender and receiver halves.
REQ-006 rst  in  1  reset, synchronous and active-low.
REQ-007 en  in  1  run enable; a rising edge starts a run and a low level aborts it.
REQ-008 do_tx  out  DATA_W  transmitted word.
REQ-009 o_req_tx / o_sdone_tx  out  1  Tx request and send-done.
REQ-010 i_ack_tx / i_rdy_tx  in  1  Tx acknowledge and ready from the far receiver.
REQ-011 di_rx  in  DATA_W  received word.
REQ-012 i_req_rx / i_sdone_rx  in  1  Rx request and send-done from the far sender.
REQ-013 o_ack_rx / o_rdy_rx  out  1  Rx acknowledge and ready.
REQ-014 led  out  1  pass indicator.
REQ-015 fail  out  1  fail indicator.
REQ-016 err_cnt  out  16  mismatch count.
REQ-017 rx_cnt  out  16  words received.

Function
REQ-018 Every control input (i_ack_tx, i_rdy_tx, i_req_rx, i_sdone_rx, en) SHALL pass through a 2-flop synchronizer before use; di_rx is sampled unsynchronized while synchronized i_req_rx is high.
REQ-019 Tx FSM SHALL implement these states:
- IDLE → WAIT_RDY on a synchronized en rising edge.
- WAIT_RDY → REQ when rdy=1, with do_tx = the current pattern word.
- REQ (o_req_tx=1) → REL when ack=1.
- REL (o_req_tx=0) → WAIT_RDY when ack=0, or → DONE once SEND_COUNT words have been sent.
- DONE (o_sdone_tx=1) → IDLE when en=0.
REQ-020 do_tx SHALL hold stable from WAIT_RDY exit until REL exit.
REQ-021 The Tx pattern generator SHALL advance exactly once per completed four-phase transfer, with wrap-around modulo 2^DATA_W.
REQ-022 Rx FSM SHALL implement these states:
- RIDLE (o_rdy_rx=1) → RACK when req=1, capturing di_rx.
- RACK (o_ack_rx=1, o_rdy_rx=0) → RIDLE when req=0.
- From any state → REND when sdone=1.
- REND: o_rdy_rx=0.
REQ-023 On each capture, Rx SHALL compare di_rx with its own expected-pattern generator (same PATTERN), increment rx_cnt, and increment err_cnt on mismatch.
REQ-024 The expected-pattern generator SHALL advance once per capture.
REQ-025 err_cnt and rx_cnt SHALL saturate at 16'hFFFF.
REQ-026 On REND entry, led SHALL be set to 1 if err_cnt==0 and rx_cnt==SEND_COUNT; otherwise fail SHALL be set to 1.
REQ-027 Reaching TIMEOUT cycles in WAIT_RDY, REQ, REL or RACK SHALL set fail=1 and send both FSMs to IDLE/RIDLE.
REQ-028 When a timeout and a capture occur in the same cycle, the capture SHALL be counted first, then the timeout taken.
REQ-029 en falling mid-run SHALL abort the run:
- Tx returns to IDLE with o_req_tx=0 on the next cycle.
- The Rx FSM continues until REND or a timeout.
REQ-030 A new en rising edge SHALL clear led, fail, err_cnt and rx_cnt and reset both generators to the seed before the first transfer.
REQ-031 led and fail SHALL be mutually exclusive; fail has priority when both conditions coincide.

Reset
REQ-032 On a clk edge with rst=0, all of the following SHALL hold:
- Both FSMs are in IDLE/RIDLE.
- do_tx=0, o_req_tx=0, o_sdone_tx=0, o_ack_rx=0, o_rdy_rx=1.
- led=0, fail=0, err_cnt=0, rx_cnt=0.
- Generators are at their seed.
- Synchronizers are cleared.
REQ-033 Reset asserted mid-transfer SHALL take effect on the same edge regardless of handshake state.

Verification
REQ-034 Loopback (Tx outputs wired to Rx inputs), PATTERN=0, DATA_W=32, SEND_COUNT=4, en rising -> words FFFFFFFF, FFFFFFFE, FFFFFFFD, FFFFFFFC; rx_cnt=4, err_cnt=0, led=1, fail=0.
REQ-035 Loopback with di_rx bit 0 forced to 1, PATTERN=1, SEND_COUNT=4 -> words 0 and 2 mismatch; err_cnt=2, fail=1, led=0.
REQ-036 i_ack_tx held at 0, TIMEOUT=16 -> fail=1 within 16+3 cycles of req rising; o_req_tx=0 afterward.
REQ-037 PATTERN=2, DATA_W=8, SEND_COUNT=9 -> words 01, 02, … 80, 01 (wrap); led=1.
REQ-038 en dropped after 2 transfers -> o_req_tx=0 within 3 cycles; the next en rise restarts at the seed with counters cleared.
REQ-039 rst=0 asserted while o_req_tx=1 -> on the next edge all outputs at reset values, o_rdy_rx=1.
